bridge_arb: RTL

- Next-generation system bridge between the MEM-stage data port and a parametrised set of memory-mapped slaves: DM, TC0, TC1 and further peripherals.
- Decodes addresses against per-slave windows and detects address exceptions (AdEL/AdES).
- Performs byte-lane alignment and load extension.
- Runs a request/ready handshake with variable-latency slaves, stalling the pipeline and raising a bus-timeout error.
- Writes to the interrupt-response address go to a dedicated port.

---
 rtl/bridge_arb_pkg.sv | 34 +++
 rtl/bridge_lane_align.sv | 57 +++++
 rtl/bridge_arb.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/bridge_arb_pkg.sv
// Shared constants for the system bridge: default slave windows, access size
// and FSM state encodings, and address exception codes.
package bridge_arb_pkg;

    // Default windows: DM, TC0, TC1 and the interrupt-response word
    localparam logic [31:0] DM_BASE       = 32'h0000_0000;
    localparam logic [31:0] DM_HIGH       = 32'h0000_2FFF;
    localparam logic [31:0] DM_WR_HIGH    = 32'h0000_2FFF;
    localparam logic [31:0] TC0_BASE      = 32'h0000_7F00;
    localparam logic [31:0] TC0_HIGH      = 32'h0000_7F0B;
    localparam logic [31:0] TC0_WR_HIGH   = 32'h0000_7F07;
    localparam logic [31:0] TC1_BASE      = 32'h0000_7F10;
    localparam logic [31:0] TC1_HIGH      = 32'h0000_7F1B;
    localparam logic [31:0] TC1_WR_HIGH   = 32'h0000_7F17;
    localparam logic [31:0] RESPONSE_ADDR = 32'h0000_7F20;

    // Address exception codes as seen by the exception unit
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_BAD  = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/bridge_lane_align.sv
// Byte-lane steering: store lane enables and data replication, load
// byte/half extraction with zero or sign extension.
module bridge_lane_align
    import bridge_arb_pkg::*;
(
    input  logic [1:0]  st_addr_lo,
    input  logic [1:0]  st_size,
    input  logic [31:0] st_data,
    output logic [3:0]  st_byteen,
    output logic [31:0] st_wdata,
    input  logic [1:0]  ld_addr_lo,
    input  logic [1:0]  ld_size,
    input  logic        ld_sign,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    function automatic logic [31:0] extend_byte(input logic [7:0] b, input logic sgn);
        logic signed [7:0] sb;
        sb = b;
        return sgn ? 32'(sb) : {24'd0, b};
    endfunction

    function automatic logic [31:0] extend_half(input logic [15:0] h, input logic sgn);
        logic signed [15:0] sh;
        sh = h;
        return sgn ? 32'(sh) : {16'd0, h};
    endfunction

    // Store side: lane enables follow the low address bits, data is replicated
    always_comb begin
        st_byteen = 4'b1111;
        st_wdata  = st_data;
        case (size_e'(st_size))
            SZ_BYTE: begin
                st_byteen = 4'b0001 << st_addr_lo;
                st_wdata  = {4{st_data[7:0]}};
            end
            SZ_HALF: begin
                st_byteen = st_addr_lo[1] ? 4'b1100 : 4'b0011;
                st_wdata  = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Load side: pick the addressed byte/half out of the word and extend it
    always_comb begin
        ld_data = ld_word;
        case (size_e'(ld_size))
            SZ_BYTE: ld_data = extend_byte(ld_word[{ld_addr_lo, 3'b000} +: 8], ld_sign);
            SZ_HALF: ld_data = extend_half(ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0], ld_sign);
            default: ;
        endcase
    end

endmodule

// File: rtl/bridge_arb.sv
// System bridge between the MEM-stage data port and memory-mapped slaves:
// window decode, address exceptions, ready handshake with timeout, and a
// dedicated port for interrupt-response stores.
module bridge_arb
    import bridge_arb_pkg::*;
#(
    parameter int                      NUM_SLV     = 3,
    parameter logic [NUM_SLV*32-1:0]   SLV_BASE    = {TC1_BASE, TC0_BASE, DM_BASE},
    parameter logic [NUM_SLV*32-1:0]   SLV_HIGH    = {TC1_HIGH, TC0_HIGH, DM_HIGH},
    parameter logic [NUM_SLV*32-1:0]   SLV_WR_HIGH = {TC1_WR_HIGH, TC0_WR_HIGH, DM_WR_HIGH},
    parameter logic [31:0]             INT_ADDR    = RESPONSE_ADDR,
    parameter int                      TIMEOUT     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   p_req,
    input  logic                   p_we,
    input  logic [1:0]             p_size,
    input  logic                   p_sign,
    input  logic [31:0]            p_addr,
    input  logic [31:0]            p_wdata,
    input  logic [31:0]            p_pc,
    output logic [31:0]            p_rdata,
    output logic                   p_done,
    output logic                   p_stall,
    output logic                   exc_adel,
    output logic                   exc_ades,
    output logic                   exc_bus,
    output logic [NUM_SLV-1:0]     s_sel,
    output logic [31:0]            s_addr,
    output logic [3:0]             s_byteen,
    output logic [31:0]            s_wdata,
    output logic [31:0]            s_pc,
    input  logic [NUM_SLV*32-1:0]  s_rdata,
    input  logic [NUM_SLV-1:0]     s_ready,
    output logic [31:0]            int_addr,
    output logic [3:0]             int_byteen
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [NUM_SLV-1:0]   sel_p1;
    logic [31:0]          addr_p1, wdata_p1, rdata_p2;
    logic [3:0]           byteen_p1;
    logic [1:0]           size_p1;
    logic                 sign_p1;

    logic [NUM_SLV-1:0]   hit_oh;
    logic                 hit_any, is_int, misaligned, bad_size, ld_bad, st_bad;
    logic [31:0]          wr_lim, sel_word, ld_ext, lane_wd;
    logic [3:0]           lane_be;
    logic                 rdy_hit, tmo;
    logic                 stall_c, adel_c, ades_c, bus_c;
    logic [3:0]           ibe_c;

    bridge_lane_align u_lane (
        .st_addr_lo (p_addr[1:0]),
        .st_size    (p_size),
        .st_data    (p_wdata),
        .st_byteen  (lane_be),
        .st_wdata   (lane_wd),
        .ld_addr_lo (addr_p1[1:0]),
        .ld_size    (size_p1),
        .ld_sign    (sign_p1),
        .ld_word    (sel_word),
        .ld_data    (ld_ext)
    );

    // Window decode: lowest-index slave wins when windows overlap
    always_comb begin
        hit_oh  = '0;
        hit_any = 1'b0;
        wr_lim  = '0;
        for (int k = 0; k < NUM_SLV; k++) begin
            if (!hit_any && p_addr >= SLV_BASE[32*k +: 32] && p_addr <= SLV_HIGH[32*k +: 32]) begin
                hit_oh[k] = 1'b1;
                hit_any   = 1'b1;
                wr_lim    = SLV_WR_HIGH[32*k +: 32];
            end
        end
        is_int     = (p_addr[31:2] == INT_ADDR[31:2]);
        misaligned = (p_size == SZ_WORD && p_addr[1:0] != 2'b00) ||
                     (p_size == SZ_HALF && p_addr[0]);
        bad_size   = (p_size == SZ_BAD);
        ld_bad     = misaligned || bad_size || (!hit_any && !is_int);
        st_bad     = misaligned || bad_size || (!is_int && (!hit_any || p_addr > wr_lim));
    end

    // Read data of the slave currently selected
    always_comb begin
        sel_word = '0;
        for (int k = 0; k < NUM_SLV; k++) begin
            if (sel_p1[k]) sel_word = sel_word | s_rdata[32*k +: 32];
        end
    end

    assign rdy_hit = |(s_ready & sel_p1);
    assign tmo     = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Next-state and combinational handshake/exception outputs
    always_comb begin
        state_d = state_q;
        stall_c = 1'b0;
        adel_c  = 1'b0;
        ades_c  = 1'b0;
        bus_c   = 1'b0;
        ibe_c   = 4'b0000;
        case (state_q)
            ST_IDLE: begin
                if (p_req) begin
                    if (p_we && st_bad) begin
                        ades_c = 1'b1;
                    end else if (!p_we && ld_bad) begin
                        adel_c = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        if (is_int) begin
                            state_d = ST_DONE;
                            if (p_we) ibe_c = lane_be;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end
                end
            end
            ST_WAIT: begin
                stall_c = 1'b1;
                if (rdy_hit) begin
                    state_d = ST_DONE;
                end else if (tmo) begin
                    bus_c   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, timeout counter and registered slave-side/result values
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            sel_p1    <= '0;
            addr_p1   <= '0;
            byteen_p1 <= '0;
            wdata_p1  <= '0;
            size_p1   <= '0;
            sign_p1   <= 1'b0;
            rdata_p2  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    cnt_q    <= '0;
                    rdata_p2 <= '0;
                    if (state_d == ST_WAIT) begin
                        sel_p1    <= hit_oh;
                        addr_p1   <= p_addr;
                        byteen_p1 <= p_we ? lane_be : 4'b0000;
                        wdata_p1  <= lane_wd;
                        size_p1   <= p_size;
                        sign_p1   <= p_sign;
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (state_d == ST_DONE) begin
                        sel_p1   <= '0;
                        cnt_q    <= '0;
                        rdata_p2 <= rdy_hit ? ld_ext : 32'd0;
                    end
                end
                default: rdata_p2 <= '0;
            endcase
        end
    end

    // -------- outputs, forced to zero while reset is asserted --------
    assign p_done     = !reset && (state_q == ST_DONE);
    assign p_rdata    = reset ? 32'd0 : rdata_p2;
    assign p_stall    = !reset && stall_c;
    assign exc_adel   = !reset && adel_c;
    assign exc_ades   = !reset && ades_c;
    assign exc_bus    = !reset && bus_c;
    assign s_sel      = reset ? '0 : sel_p1;
    assign s_addr     = reset ? 32'd0 : addr_p1;
    assign s_byteen   = reset ? 4'd0 : byteen_p1;
    assign s_wdata    = reset ? 32'd0 : wdata_p1;
    assign s_pc       = reset ? 32'd0 : p_pc;
    assign int_addr   = reset ? 32'd0 : p_addr;
    assign int_byteen = reset ? 4'd0 : ibe_c;

endmodule
